// File: rtl/calc_pkg.sv
// Shared calculator constants: digit count, segment width, status codes.
// Also holds the segment polarity helper used by the display scanner.
package calc_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int SEG_W      = 7;

   typedef enum logic [1:0] {
      STATUS_IDLE = 2'b00,
      STATUS_BUSY = 2'b01,
      STATUS_ERR  = 2'b10,
      STATUS_OVF  = 2'b11
   } status_e;

   // Pattern with every segment dark, in lit-high terms.
   localparam logic [SEG_W-1:0] SEG_OFF = '0;

   function automatic logic [SEG_W-1:0] seg_drive(
      input logic [SEG_W-1:0] pat,
      input bit               act_low
   );
      return act_low ? ~pat : pat;
   endfunction

endpackage

// File: rtl/scan_tick.sv
// Modulo-DIV tick counter: counts enabled cycles, ticks on the last one.
// Ports: clock, reset (sync, active-low), en, clr, tick, cnt_nxt (next count).
module scan_tick #(
   parameter int DIV = 4,
   parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic         tick,
   output logic [W-1:0] cnt_nxt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick = en && (cnt_q == W'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Next value is exported so callers can register outputs in step with it.
   assign cnt_nxt = cnt_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 8-digit 7-segment scanner with per-slot anti-ghost blanking.
// Ports: clock, reset (sync, active-low), displays[8][7], status[2],
//   seg[7] (registered), an[8] (active-low one-hot, registered), digit_idx[3].
// Optional blink on STATUS_ERR when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan
   import calc_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter int BLINK_SLOTS    = 4096,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_DIGITS-1:0][SEG_W-1:0] displays,
   input  logic [1:0]                       status,
   output logic [SEG_W-1:0]                 seg,
   output logic [NUM_DIGITS-1:0]            an,
   output logic [2:0]                       digit_idx
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] BLANK_V = PW'(BLANK_CYCLES);

   logic          slot_tick;
   logic [PW-1:0] pre_nxt;
   logic          hide_d;

   logic [2:0]            idx_q,  idx_d;
   logic [SEG_W-1:0]      hold_q, hold_d;
   logic [SEG_W-1:0]      seg_q,  seg_d;
   logic [NUM_DIGITS-1:0] an_q,   an_d;

   scan_tick #(
      .DIV (SCAN_DIV),
      .W   (PW)
   ) u_slot (
      .clock   (clock),
      .reset   (reset),
      .en      (1'b1),
      .clr     (1'b0),
      .tick    (slot_tick),
      .cnt_nxt (pre_nxt)
   );

`ifdef DISPLAY_SCAN_BLINK_EN
   localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

   logic          is_err;
   logic          blink_tick;
   logic          hid_q, hid_d;
   logic [BW-1:0] unused_bcnt;

   assign is_err = (status == STATUS_ERR);

   // Leaving the error state clears both the counter and the phase.
   scan_tick #(
      .DIV (BLINK_SLOTS),
      .W   (BW)
   ) u_blink (
      .clock   (clock),
      .reset   (reset),
      .en      (slot_tick & is_err),
      .clr     (!is_err),
      .tick    (blink_tick),
      .cnt_nxt (unused_bcnt)
   );

   always_comb begin
      hid_d = 1'b0;
      if (is_err) begin
         hid_d = hid_q ^ blink_tick;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hid_q <= 1'b0;
      end else begin
         hid_q <= hid_d;
      end
   end

   assign hide_d = hid_d;
`else
   localparam int unused_blink_slots = BLINK_SLOTS;
   logic unused_status;
   assign unused_status = ^status;
   assign hide_d = 1'b0;
`endif

   // Outputs are registered from next-state values so seg, an and
   // digit_idx all move on the edge that ends the slot tick.
   always_comb begin
      idx_d  = idx_q;
      hold_d = hold_q;
      if (slot_tick) begin
         idx_d  = idx_q + 3'd1;
         hold_d = displays[idx_d];
      end
      seg_d = seg_drive(hold_d, SEG_ACTIVE_LOW);
      an_d  = '1;
      if (!((pre_nxt < BLANK_V) || hide_d)) begin
         an_d[idx_d] = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         idx_q  <= '0;
         hold_q <= displays[0];
         seg_q  <= seg_drive(SEG_OFF, SEG_ACTIVE_LOW);
         an_q   <= '1;
      end else begin
         idx_q  <= idx_d;
         hold_q <= hold_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: reset, scan walk, snapshot, mid reset,
// and blink (or its absence, depending on DISPLAY_SCAN_BLINK_EN).
module tb_display_scan;
   import calc_pkg::*;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [7:0][6:0] displays;
   logic [1:0]      status = 2'b00;
   logic [6:0]      seg;
   logic [7:0]      an;
   logic [2:0]      digit_idx;

   int n_chk  = 0;
   int n_fail = 0;
   int k      = 0;

   always #5 clock = ~clock;

   display_scan #(
      .SCAN_DIV       (4),
      .BLANK_CYCLES   (1),
      .BLINK_SLOTS    (2),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .displays  (displays),
      .status    (status),
      .seg       (seg),
      .an        (an),
      .digit_idx (digit_idx)
   );

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic [2:0] idx;
   } vec_t;

   vec_t vec [37];

   logic [7:0] an_lit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [6:0] disp_lit [8] = '{7'h01, 7'h02, 7'h04, 7'h08,
                                7'h10, 7'h20, 7'h40, 7'h01};

   task automatic cmp(string nm, logic [7:0] got, logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk(string nm, logic [7:0] a, logic [6:0] s,
                      logic [2:0] i);
      cmp({nm, ".an"}, an, a);
      cmp({nm, ".seg"}, {1'b0, seg}, {1'b0, s});
      cmp({nm, ".idx"}, {5'b0, digit_idx}, {5'b0, i});
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
      k++;
   endtask

   task automatic run_to(int target);
      while (k < target) cyc();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) displays[i] = disp_lit[i];

      // Expected scan, k = cycles since the first edge after reset.
      for (int j = 0; j < 37; j++) begin
         vec[j].idx = 3'((j / 4) % 8);
         vec[j].an  = (j % 4 == 0) ? 8'hFF : an_lit[(j / 4) % 8];
         vec[j].seg = (j == 0) ? 7'h7F : ~disp_lit[(j / 4) % 8];
      end

      // Reset held for three cycles.
      for (int r = 0; r < 3; r++) begin
         cyc();
         chk($sformatf("rst%0d", r), 8'hFF, 7'h7F, 3'd0);
      end

      reset = 1'b1;
      k = 0;
      for (int j = 0; j < 37; j++) begin
         if (j > 0) cyc();
         chk($sformatf("scan%0d", j), vec[j].an, vec[j].seg, vec[j].idx);
      end

      // Snapshot: displays[3] changes mid-slot 3.
      reset = 1'b0;
      displays[3] = 7'h3F;
      cyc();
      reset = 1'b1;
      k = 0;
      run_to(14);
      chk("snap_pre", 8'hF7, 7'h40, 3'd3);
      displays[3] = 7'h06;
      cyc();
      chk("snap_hold", 8'hF7, 7'h40, 3'd3);
      cyc();
      chk("snap_d4", 8'hFF, 7'h6F, 3'd4);
      run_to(40);
      chk("snap_d2", 8'hFF, 7'h7B, 3'd2);
      run_to(44);
      chk("snap_new", 8'hFF, 7'h79, 3'd3);
      cyc();
      chk("snap_new2", 8'hF7, 7'h79, 3'd3);

      // Reset mid-slot at digit 5.
      run_to(54);
      chk("pre_mrst", 8'hDF, 7'h5F, 3'd5);
      reset = 1'b0;
      cyc();
      chk("mrst", 8'hFF, 7'h7F, 3'd0);
      reset = 1'b1;
      status = 2'b10;
      k = 0;

      run_to(1);
      chk("rs_d0", 8'hFE, 7'h7E, 3'd0);
      run_to(5);
      chk("rs_d1", 8'hFD, 7'h7D, 3'd1);
`ifdef DISPLAY_SCAN_BLINK_EN
      run_to(9);
      chk("blk_d2", 8'hFF, 7'h7B, 3'd2);
      run_to(13);
      chk("blk_d3", 8'hFF, 7'h79, 3'd3);
      run_to(17);
      chk("blk_d4", 8'hEF, 7'h6F, 3'd4);
      run_to(25);
      chk("blk_d6", 8'hFF, 7'h3F, 3'd6);
`else
      run_to(9);
      chk("nb_d2", 8'hFB, 7'h7B, 3'd2);
      run_to(13);
      chk("nb_d3", 8'hF7, 7'h79, 3'd3);
      run_to(17);
      chk("nb_d4", 8'hEF, 7'h6F, 3'd4);
      run_to(25);
      chk("nb_d6", 8'hBF, 7'h3F, 3'd6);
`endif
      run_to(26);
      status = 2'b00;
      cyc();
      chk("unblk", 8'hBF, 7'h3F, 3'd6);
      run_to(29);
      chk("unblk_d7", 8'h7F, 7'h7E, 3'd7);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
